// File: rtl/collision_engine.sv
// Frame-synchronous ball/paddle/floor/ceiling collision detector; one paddle per cycle.
// Result valid N_PADDLES cycles after the tick edge, held until resultReady; ticks while busy are dropped and flagged.
module collision_engine #(
  parameter int         BIT_WIDTH       = 10,
  parameter int         N_PADDLES       = 2,
  parameter int         BALL_RADIUS     = 4,
  parameter int         PADDLE_RADIUS   = 16,
  parameter int         FLOOR_Y         = 0,
  parameter int         CEIL_Y          = 479,
  parameter logic [7:0] PADDLE_FACING   = 8'h01,
  parameter int         COOLDOWN_FRAMES = 3,
  localparam int        IDX_W           = (N_PADDLES > 1) ? $clog2(N_PADDLES) : 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           frameTick,
  input  logic [BIT_WIDTH-1:0]           ballX,
  input  logic [BIT_WIDTH-1:0]           ballY,
  input  logic                           ballDirX,
  input  logic                           ballDirY,
  input  logic [N_PADDLES*BIT_WIDTH-1:0] paddleX,
  input  logic [N_PADDLES*BIT_WIDTH-1:0] paddleY,
  output logic                           resultValid,
  input  logic                           resultReady,
  output logic                           paddleHit,
  output logic [IDX_W-1:0]               hitIndex,
  output logic signed [BIT_WIDTH:0]      hitOffset,
  output logic                           floorHit,
  output logic                           ceilHit,
  output logic                           tickMissed
);

  localparam int SW   = BIT_WIDTH + 2;
  localparam int CD_W = $clog2(COOLDOWN_FRAMES + 1);
  localparam logic signed [SW-1:0] BR_S = SW'(BALL_RADIUS);
  localparam logic signed [SW-1:0] PR_S = SW'(PADDLE_RADIUS);
  localparam logic signed [SW-1:0] FL_S = SW'(FLOOR_Y);
  localparam logic signed [SW-1:0] CE_S = SW'(CEIL_Y);

  typedef enum logic [1:0] {IDLE, SCAN, REPORT} state_t;

  state_t               state, state_nxt;
  logic [IDX_W-1:0]     idx;
  logic                 idx_last;
  logic                 tick_take, scan_en, scan_done;

  logic [BIT_WIDTH-1:0] bx_q, by_q;
  logic                 dirx_q, diry_q;
  logic [BIT_WIDTH-1:0] px_q [N_PADDLES];
  logic [BIT_WIDTH-1:0] py_q [N_PADDLES];
  logic [CD_W-1:0]      cooldown [N_PADDLES];

  logic signed [SW-1:0]      s_bx, s_by, s_px, s_py, dx, adx;
  logic signed [BIT_WIDTH:0] off_now;
  logic                      x_ok, y_ok, dir_ok, cd_ok, hit_now, floor_now, ceil_now;

  assign idx_last = (idx == IDX_W'(N_PADDLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (frameTick)   state_nxt = SCAN;
      SCAN:    if (idx_last)    state_nxt = REPORT;
      REPORT:  if (resultReady) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    resultValid = (state == REPORT);
    tick_take   = (state == IDLE) && frameTick;
    scan_en     = (state == SCAN);
    scan_done   = (state == SCAN) && idx_last;
  end

  // Widened signed arithmetic so paddle extents near 0 go negative instead of wrapping.
  always_comb begin
    s_bx      = $signed({2'b00, bx_q});
    s_by      = $signed({2'b00, by_q});
    s_px      = $signed({2'b00, px_q[idx]});
    s_py      = $signed({2'b00, py_q[idx]});
    dx        = s_bx - s_px;
    adx       = (dx < 0) ? -dx : dx;
    x_ok      = (adx <= BR_S);
    y_ok      = (s_by >= s_py - PR_S - BR_S) && (s_by <= s_py + PR_S + BR_S);
    dir_ok    = PADDLE_FACING[idx] ? !dirx_q : dirx_q;
    cd_ok     = (cooldown[idx] == '0);
    hit_now   = scan_en && !paddleHit && x_ok && y_ok && dir_ok && cd_ok;
    off_now   = $signed({1'b0, by_q}) - $signed({1'b0, py_q[idx]});
    floor_now = (s_by <= FL_S + BR_S) && !diry_q;
    ceil_now  = (s_by + BR_S >= CE_S) && diry_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx        <= '0;
      bx_q       <= '0;
      by_q       <= '0;
      dirx_q     <= 1'b0;
      diry_q     <= 1'b0;
      paddleHit  <= 1'b0;
      hitIndex   <= '0;
      hitOffset  <= '0;
      floorHit   <= 1'b0;
      ceilHit    <= 1'b0;
      tickMissed <= 1'b0;
      for (int i = 0; i < N_PADDLES; i++) begin
        px_q[i]     <= '0;
        py_q[i]     <= '0;
        cooldown[i] <= '0;
      end
    end else begin
      if (tick_take) begin
        idx       <= '0;
        bx_q      <= ballX;
        by_q      <= ballY;
        dirx_q    <= ballDirX;
        diry_q    <= ballDirY;
        paddleHit <= 1'b0;
        hitIndex  <= '0;
        hitOffset <= '0;
        for (int i = 0; i < N_PADDLES; i++) begin
          px_q[i] <= paddleX[i*BIT_WIDTH +: BIT_WIDTH];
          py_q[i] <= paddleY[i*BIT_WIDTH +: BIT_WIDTH];
          if (cooldown[i] != '0) cooldown[i] <= cooldown[i] - 1'b1;
        end
      end
      if (scan_en) begin
        idx <= idx + 1'b1;
        if (hit_now) begin
          paddleHit     <= 1'b1;
          hitIndex      <= idx;
          hitOffset     <= off_now;
          cooldown[idx] <= CD_W'(COOLDOWN_FRAMES);
        end
      end
      if (scan_done) begin
        floorHit <= floor_now;
        ceilHit  <= ceil_now;
      end
      if (frameTick && (state != IDLE)) tickMissed <= 1'b1;
    end
  end

endmodule

// File: doc/collision_engine.md
Name: collision_engine

Overview:
Multi-paddle, frame-synchronous collision detector for the Pong datapath. On each frame tick it snapshots ball state and all paddle positions, scans the paddles sequentially (one per cycle) with direction-aware hit tests, and also checks floor and ceiling. It returns one registered result record over a valid/ready handshake to the ball-physics block. Per-paddle cooldown counters suppress repeated hits on the same paddle across consecutive frames.

Parameters:
BIT_WIDTH, 10, coordinate width (unsigned)
N_PADDLES, 2, number of paddles (1..8)
BALL_RADIUS, 4, ball half-size in pixels
PADDLE_RADIUS, 16, paddle half-height in pixels
FLOOR_Y, 0, floor Y coordinate
CEIL_Y, 479, ceiling Y coordinate
PADDLE_FACING, 2'b01, bit i=1: paddle i faces +X (left-side paddle); bit i=0: faces -X
COOLDOWN_FRAMES, 3, frames a paddle is ignored after a hit (>=1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
frameTick  in  1  one-cycle pulse, start of evaluation
ballX  in  BIT_WIDTH  ball centre X
ballY  in  BIT_WIDTH  ball centre Y
ballDirX  in  1  1 = moving +X
ballDirY  in  1  1 = moving +Y (up)
paddleX  in  N_PADDLES*BIT_WIDTH  packed paddle centre X, paddle i at [i*BIT_WIDTH +: BIT_WIDTH]
paddleY  in  N_PADDLES*BIT_WIDTH  packed paddle centre Y, same packing
resultValid  out  1  result record valid
resultReady  in  1  consumer accepts result
paddleHit  out  1  a paddle hit occurred this frame
hitIndex  out  $clog2(N_PADDLES) (min 1)  index of winning paddle
hitOffset  out  BIT_WIDTH+1 signed  ballY - paddleY[hitIndex]
floorHit  out  1  ball touching/below floor while moving down
ceilHit  out  1  ball touching/above ceiling while moving up
tickMissed  out  1  sticky: frameTick arrived while busy

Behaviour:
- Reset (async, rst_n=0): state IDLE; resultValid, paddleHit, floorHit, ceilHit, tickMissed = 0; hitIndex = 0; hitOffset = 0; all cooldown counters = 0. Reset mid-scan or mid-report aborts; no result is emitted.
- States: IDLE, SCAN, REPORT.
- IDLE, frameTick=1: latch ballX/Y, ballDirX/Y, paddleX/Y into snapshot registers. Decrement every nonzero cooldown counter (saturate at 0). Clear hit accumulators. Go to SCAN with idx=0.
- SCAN: evaluate paddle idx against the snapshot; idx increments each cycle. After idx=N_PADDLES-1, go to REPORT and set resultValid=1. resultValid first reads high N_PADDLES cycles after the tick edge.
- Hit test for paddle i (all arithmetic signed, BIT_WIDTH+2 bits, no wrap at 0):
  - |ballX - pX| <= BALL_RADIUS; and
  - pY-PADDLE_RADIUS-BALL_RADIUS <= ballY <= pY+PADDLE_RADIUS+BALL_RADIUS (inclusive); and
  - approaching: PADDLE_FACING[i]=1 requires ballDirX=0; PADDLE_FACING[i]=0 requires ballDirX=1; and
  - cooldown[i]==0.
- Priority: the lowest-index hitting paddle wins. Later hits in the same scan are ignored and their cooldowns are untouched.
- On win: set paddleHit=1, hitIndex=i, hitOffset=ballY-pY, cooldown[i]=COOLDOWN_FRAMES.
- floorHit = (ballY <= FLOOR_Y+BALL_RADIUS) && ballDirY==0. ceilHit = (ballY+BALL_RADIUS >= CEIL_Y) && ballDirY==1. Both are computed from the snapshot and registered on entry to REPORT. Floor, ceiling and paddle hits may all be set in the same result.
- With no paddle hit: hitIndex=0, hitOffset=0.
- REPORT: all result outputs are held stable while resultValid=1. When resultValid && resultReady at an edge: resultValid drops to 0, go to IDLE. The result fields keep their values until the next scan begins.
- frameTick in SCAN or REPORT: tick is dropped, tickMissed set (sticky until reset), no cooldown decrement. frameTick in the same cycle as the accepting handshake is also dropped, because the state is still REPORT.
- Inputs may change freely after the tick edge; only the snapshot is used.

Test Plan:
- Reset then idle: rst_n low mid-SCAN -> all outputs 0; no resultValid for 10 cycles after release without a tick.
- Single hit, N=2: paddle0 (facing +X) at X=20,Y=200; ball X=22,Y=210, dirX=0; tick -> resultValid 2 cycles later, paddleHit=1, hitIndex=0, hitOffset=+10, floor/ceil 0.
- Direction gating and edge: same geometry with dirX=1 -> paddleHit=0. Ball Y=220 (exact limit 200+16+4) dirX=0 -> hit. Ball Y=221 -> no hit.
- Cooldown: hit paddle0, then 3 more ticks with the same geometry -> hits on ticks 1 and 4 only (COOLDOWN_FRAMES=3).
- Floor/ceiling plus backpressure: ballY=3, dirY=0, resultReady held 0 for 5 cycles -> floorHit=1 and outputs stable throughout. Tick during the wait -> tickMissed=1. resultReady=1 -> resultValid clears next edge.
- Priority, N=4: paddles 1 and 3 both satisfy the hit test -> hitIndex=1. Paddle3 cooldown stays 0 and it hits on the next tick.
